// File: rtl/ro_freq_counter.sv
// Frequency counter for a free-running oscillator: gates its enable, synchronizes
// its output into clk and counts rising edges over a fixed window of clk cycles.
`timescale 1ns/1ps
module ro_freq_counter #(
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ro_in,
  output logic             ro_en,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             cnt_valid,
  input  logic             cnt_ready
);

  localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

  state_t                 state, state_d;
  logic [SYNC_STAGES-1:0] sync_pipe;
  logic                   prev;
  logic [TW-1:0]          timer;
  logic                   sync_out, rise;

  assign sync_out = sync_pipe[SYNC_STAGES-1];
  assign rise     = sync_out & ~prev;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // SETTLE spans SETTLE_CYCLES+1 edges so that start at edge k yields
  // cnt_valid right after edge k+SETTLE_CYCLES+GATE_CYCLES+1.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start)                          state_d = SETTLE;
      SETTLE:  if (timer == TW'(SETTLE_CYCLES))    state_d = MEASURE;
      MEASURE: if (timer == TW'(GATE_CYCLES - 1))  state_d = DONE;
      DONE:    if (cnt_ready)                      state_d = IDLE;
      default:                                     state_d = IDLE;
    endcase
  end

  // prev follows the synchronized input in every state, so a level already
  // high when MEASURE opens is not mistaken for an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      prev      <= 1'b0;
      timer     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      ro_en     <= 1'b0;
      cnt_valid <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], ro_in};
      prev      <= sync_out;
      timer     <= (state_d == state && (state == SETTLE || state == MEASURE))
                   ? timer + 1'b1 : '0;
      ro_en     <= (state_d == SETTLE || state_d == MEASURE);
      cnt_valid <= (state_d == DONE);
      if (state == IDLE && start) begin
        count    <= '0;
        overflow <= 1'b0;
      end else if (state == MEASURE && rise) begin
        if (&count) overflow <= 1'b1;
        else        count    <= count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Directed bench: two counters (16-bit and 4-bit count) share clk and ro_in.
`timescale 1ns/1ps
module tb_ro_freq_counter;

  localparam int G   = 100;
  localparam int S   = 8;
  localparam int LAT = S + G + 2;   // edges from setting start to cnt_valid seen

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cnt_ready = 1'b0, ro_in = 1'b0;
  logic ro_en_a, busy_a, ovf_a, vld_a;
  logic ro_en_b, busy_b, ovf_b, vld_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0, failures = 0;
  int ro_half = 20;
  logic ro_lvl = 1'b0;

  ro_freq_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .SYNC_STAGES(2), .CNT_W(16)) ua (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_in(ro_in), .ro_en(ro_en_a),
    .busy(busy_a), .count(cnt_a), .overflow(ovf_a), .cnt_valid(vld_a), .cnt_ready(cnt_ready));

  ro_freq_counter #(.GATE_CYCLES(G), .SETTLE_CYCLES(S), .SYNC_STAGES(2), .CNT_W(4)) ub (
    .clk(clk), .rst_n(rst_n), .start(start), .ro_in(ro_in), .ro_en(ro_en_b),
    .busy(busy_b), .count(cnt_b), .overflow(ovf_b), .cnt_valid(vld_b), .cnt_ready(cnt_ready));

  always #5 clk = ~clk;

  // oscillator model: square wave with half period ro_half ns, or static ro_lvl
  initial begin
    #3;
    forever begin
      if (ro_half == 0) begin ro_in = ro_lvl; #1; end
      else begin #(ro_half) ro_in = ~ro_in; end
    end
  end

  task automatic chk(input string tag, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (vld_a !== 1'b1 && n < 400) begin @(posedge clk); #1; n++; end
  endtask

  task automatic chk_result(input string tag, input int alo, input int ahi,
                            input int blo, input int bhi, input int bovf);
    chk({tag, "_vld_b"}, int'(vld_b), 1, 1);
    chk({tag, "_cnt_a"}, int'(cnt_a), alo, ahi);
    chk({tag, "_ovf_a"}, int'(ovf_a), 0, 0);
    chk({tag, "_cnt_b"}, int'(cnt_b), blo, bhi);
    chk({tag, "_ovf_b"}, int'(ovf_b), bovf, bovf);
    chk({tag, "_roen_off"}, int'({ro_en_a, ro_en_b}), 0, 0);
  endtask

  // start pulse, latency and result; leaves the DUTs waiting in DONE
  task automatic launch(input string tag, input int alo, input int ahi,
                        input int blo, input int bhi, input int bovf);
    int n;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk({tag, "_roen"}, int'({ro_en_a, ro_en_b}), 3, 3);
    chk({tag, "_busy"}, int'({busy_a, busy_b}), 3, 3);
    wait_valid(n);
    chk({tag, "_lat"}, n + 1, LAT, LAT);
    chk_result(tag, alo, ahi, blo, bhi, bovf);
  endtask

  task automatic ack(input string tag);
    cnt_ready = 1'b1;
    tick(1);
    cnt_ready = 1'b0;
    chk({tag, "_ack_vld"}, int'({vld_a, vld_b}), 0, 0);
    chk({tag, "_ack_busy"}, int'({busy_a, busy_b}), 0, 0);
  endtask

  initial begin
    int n;
    logic [15:0] snap_a;
    logic [3:0]  snap_b;
    logic        stable;

    #12;
    chk("rst_a", int'({ro_en_a, busy_a, vld_a, ovf_a}), 0, 0);
    chk("rst_cnt_a", int'(cnt_a), 0, 0);
    chk("rst_b", int'({ro_en_b, busy_b, vld_b, ovf_b, cnt_b}), 0, 0);
    rst_n = 1'b1;
    tick(3);

    // nominal 40 ns period: 25 edges in 100 cycles; 4-bit counter saturates
    launch("nom", 24, 26, 15, 15, 1);
    ack("nom");

    // 200 ns period: 5 edges; overflow from the previous run is cleared
    ro_half = 100;
    tick(30);
    launch("slow", 4, 6, 4, 6, 0);
    ack("slow");

    ro_half = 0; ro_lvl = 1'b0;
    tick(30);
    launch("low", 0, 0, 0, 0, 0);
    ack("low");

    ro_lvl = 1'b1;
    tick(30);
    launch("high", 0, 0, 0, 0, 0);
    ack("high");

    // backpressure: result held in DONE, start pulses ignored
    ro_half = 20;
    tick(30);
    launch("bp", 24, 26, 15, 15, 1);
    snap_a = cnt_a; snap_b = cnt_b; stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      start = i[0];
      tick(1);
      if (cnt_a !== snap_a || cnt_b !== snap_b || vld_a !== 1'b1 || vld_b !== 1'b1 ||
          ovf_b !== 1'b1 || ovf_a !== 1'b0 || ro_en_a !== 1'b0 || ro_en_b !== 1'b0)
        stable = 1'b0;
    end
    start = 1'b0;
    chk("bp_stable", int'(stable), 1, 1);
    ack("bp");
    tick(1);
    chk("bp_idle", int'({busy_a, busy_b}), 0, 0);

    // asynchronous reset 60 cycles into the window
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(S + 1 + 60);
    chk("mid_cnt_pre", int'(cnt_a), 10, 20);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_a", int'({ro_en_a, busy_a, vld_a, ovf_a}), 0, 0);
    chk("mid_rst_cnt_a", int'(cnt_a), 0, 0);
    chk("mid_rst_b", int'({ro_en_b, busy_b, vld_b, ovf_b, cnt_b}), 0, 0);
    #2;
    rst_n = 1'b1;
    tick(3);
    launch("post", 24, 26, 15, 15, 1);
    ack("post");

    // back-to-back: start and cnt_ready held high
    start = 1'b1;
    cnt_ready = 1'b1;
    wait_valid(n);
    chk("b2b0_lat", n, LAT, LAT);
    chk_result("b2b0", 24, 26, 15, 15, 1);
    for (int r = 1; r < 3; r++) begin
      tick(1);
      chk($sformatf("b2b%0d_idle", r), int'({busy_a, busy_b, vld_a}), 0, 0);
      wait_valid(n);
      chk($sformatf("b2b%0d_lat", r), n + 1, LAT + 1, LAT + 1);
      chk_result($sformatf("b2b%0d", r), 24, 26, 15, 15, 1);
    end
    start = 1'b0;
    tick(1);
    cnt_ready = 1'b0;
    tick(1);
    chk("b2b_end", int'({busy_a, busy_b, vld_a, vld_b}), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
